mem_controller: RTL and testbench
=================================

Name: mem_controller

Overview:
- Responder end of the LSB memory query interface, and also serves instruction-fetch word reads.
- Sits between the execute/fetch units and the single byte-wide RAM/IO port.
- Splits each byte/halfword/word request into little-endian single-byte RAM accesses, reassembles read data, and returns a one-cycle reply pulse.
- Arbitrates two clients: LSB has priority over fetch; no preemption.

Parameters:
- IO_ADDR_HI, 32'h00030000, addresses with bits [17:16]==2'b11 are IO; writes to them obey io_buffer_full.

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  synchronous active-high reset.
- rdy_in  input  1  global pause; when 0, all state holds and mem_wr is forced to 0.
- flush_signal  input  1  misprediction flush from RoB.
- lsb_query_en  input  1  LSB request, held high until the reply is seen.
- lsb_query_type  input  1  0 read, 1 write.
- lsb_query_addr  input  32  byte address.
- lsb_data_width  input  2  0 byte, 1 half, 2 word; 3 is treated as word.
- lsb_query_data  input  32  write data, low bytes used.
- lsb_reply_en  output  1  one-cycle completion pulse.
- lsb_reply_data  output  32  read data, zero-extended; 0 for writes.
- if_query_en  input  1  fetch word-read request, held until reply.
- if_query_addr  input  32  fetch address.
- if_reply_en  output  1  one-cycle completion pulse.
- if_reply_data  output  32  fetched word.
- mem_din  input  8  RAM read byte; valid one cycle after the address is driven.
- mem_dout  output  8  RAM write byte.
- mem_a  output  32  RAM address.
- mem_wr  output  1  1 = write this cycle.
- io_buffer_full  input  1  IO write buffer full.

Behaviour:
- Reset: state IDLE. All outputs 0: mem_a, mem_dout, mem_wr, lsb_reply_en, lsb_reply_data, if_reply_en, if_reply_data. Byte counter and assembly register cleared.
- States: IDLE, READ, WRITE, DONE.
- IDLE arbitration:
  - If lsb_query_en: latch addr, width (N = 1/2/4 bytes), type, data, and owner=LSB.
  - Else if if_query_en: latch addr, N=4, owner=IF.
  - Go to READ or WRITE; the accepting edge is e.
- READ:
  - Drive mem_a = addr+k, mem_wr=0, for k=0..N-1 in cycles e+1..e+N.
  - mem_din sampled in cycle c+1 fills byte lane k.
  - After the last byte is captured (edge e+N+1), pulse the owner's reply_en with the assembled word; upper unused bytes are 0.
  - Go to DONE.
- WRITE:
  - Drive mem_wr=1, mem_a=addr+k, mem_dout=data[8k+7:8k] in cycles e+1..e+N.
  - If the address is IO and io_buffer_full=1 at a step, hold that byte with mem_wr=0 and retry the next cycle.
  - After the last byte, pulse lsb_reply_en with data 0, then go to DONE.
- DONE: exactly one cycle, ignores both requests (the client drops en on the edge where it sees the reply), then IDLE.
- Reply pulses are one cycle wide; the reply data value is held until the next reply.
- Address arithmetic is 32-bit wrapping; crossing 0xFFFFFFFF wraps to 0.
- mem_wr is 0 in every cycle not explicitly writing, including READ, DONE, IDLE and pause.
- Flush:
  - During READ (either owner): abort, no reply, go to DONE.
  - During WRITE: the store is already committed, so all bytes are completed; the reply is still pulsed.
  - In IDLE the flush cycle accepts no request.
- Simultaneous LSB and IF requests in IDLE: LSB is served first; IF stays pending and is served after DONE.
- rdy_in=0 mid-operation: freeze the counter, state and outputs, with mem_wr=0. Resume at the same byte; a read re-drives the address before sampling.
- Reset mid-operation: immediate return to the reset values above; a partial write is not completed.

Test Plan:
- LSB lw at 0x100, RAM bytes 11 22 33 44 -> mem_a 0x100..0x103 on consecutive cycles; lsb_reply_data=0x44332211 pulsed at e+5; mem_wr always 0.
- LSB sh addr 0x202, data 0xDEADBEEF -> mem_wr=1 for two cycles writing EF@0x202, BE@0x203; single reply pulse, data 0; no request accepted in DONE.
- LSB lb and IF fetch asserted same cycle at 0x10/0x0 -> LSB served first (1 byte, reply e+2); IF mem_a 0x0..0x3 starts after DONE; if_reply_data correct.
- flush during IF read after 2 bytes -> no if_reply_en, return to IDLE via DONE; flush during sw -> all 4 bytes written, reply pulsed.
- sb to 0x30000 with io_buffer_full high 3 cycles -> mem_wr held 0 for those cycles, byte written on the first cycle it is low, then reply.
- rdy_in low 2 cycles mid lw and rst_in mid sw -> read result unchanged and delayed 2 cycles; reset drives all outputs 0, state IDLE next cycle.

Source files
------------

// File: rtl/mem_controller.sv
// mem_controller: single-port byte-wide RAM/IO front end.
// Serves LSB byte/half/word loads and stores plus instruction-fetch word reads.
// Each request becomes a run of little-endian single-byte RAM accesses. Reads
// are pipelined one byte per cycle and reassembled into a 32-bit reply.
module mem_controller #(
    parameter logic [31:0] IO_ADDR_HI = 32'h00030000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        flush_signal,
    input  logic        lsb_query_en,
    input  logic        lsb_query_type,
    input  logic [31:0] lsb_query_addr,
    input  logic [1:0]  lsb_data_width,
    input  logic [31:0] lsb_query_data,
    output logic        lsb_reply_en,
    output logic [31:0] lsb_reply_data,
    input  logic        if_query_en,
    input  logic [31:0] if_query_addr,
    output logic        if_reply_en,
    output logic [31:0] if_reply_data,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t      state;
    logic [31:0] base_addr;  // first byte address of the request
    logic [31:0] wdata;      // store data, lane k goes out on step k
    logic [1:0]  last;       // lane index of the final byte (0, 1 or 3)
    logic        owner_if;   // 1 when the current read belongs to fetch
    logic [1:0]  k;          // lane whose address is on mem_a
    logic        a_vld;      // mem_a carries a read address still to be used
    logic [1:0]  cap;        // lane whose data is on mem_din this cycle
    logic        cap_vld;    // mem_din carries useful read data this cycle
    logic [31:0] asm_q;      // read bytes collected so far
    logic        wr_q;       // a store byte is being presented
    logic        paused_q;   // previous cycle was a global pause
    logic        io_blk;     // current store byte targets IO while its buffer is full

    function automatic logic [1:0] last_lane(input logic [1:0] w);
        case (w)
            2'd0:    return 2'd0;
            2'd1:    return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] lane,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = w;
        r[{lane, 3'b000} +: 8] = b;
        return r;
    endfunction

    function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] lane);
        return w[{lane, 3'b000} +: 8];
    endfunction

    // A store byte to IO waits while the IO buffer is full; pause also gates the strobe.
    assign io_blk = ((mem_a & IO_ADDR_HI) == IO_ADDR_HI) && io_buffer_full;
    assign mem_wr = wr_q && rdy_in && !io_blk;

    // Request arbitration, byte sequencing, read reassembly and reply generation.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state          <= IDLE;
            mem_a          <= '0;
            mem_dout       <= '0;
            wr_q           <= 1'b0;
            lsb_reply_en   <= 1'b0;
            lsb_reply_data <= '0;
            if_reply_en    <= 1'b0;
            if_reply_data  <= '0;
            base_addr      <= '0;
            wdata          <= '0;
            last           <= '0;
            owner_if       <= 1'b0;
            k              <= '0;
            a_vld          <= 1'b0;
            cap            <= '0;
            cap_vld        <= 1'b0;
            asm_q          <= '0;
            paused_q       <= 1'b0;
        end else if (!rdy_in) begin
            paused_q <= 1'b1;
        end else begin
            paused_q     <= 1'b0;
            lsb_reply_en <= 1'b0;
            if_reply_en  <= 1'b0;
            case (state)
                IDLE: begin
                    if (!flush_signal) begin
                        if (lsb_query_en) begin
                            base_addr <= lsb_query_addr;
                            wdata     <= lsb_query_data;
                            last      <= last_lane(lsb_data_width);
                            owner_if  <= 1'b0;
                            mem_a     <= lsb_query_addr;
                            k         <= '0;
                            asm_q     <= '0;
                            cap_vld   <= 1'b0;
                            if (lsb_query_type) begin
                                wr_q     <= 1'b1;
                                mem_dout <= lsb_query_data[7:0];
                                state    <= WRITE;
                            end else begin
                                a_vld <= 1'b1;
                                state <= READ;
                            end
                        end else if (if_query_en) begin
                            base_addr <= if_query_addr;
                            last      <= 2'd3;
                            owner_if  <= 1'b1;
                            mem_a     <= if_query_addr;
                            k         <= '0;
                            asm_q     <= '0;
                            a_vld     <= 1'b1;
                            cap_vld   <= 1'b0;
                            state     <= READ;
                        end
                    end
                end
                READ: begin
                    if (flush_signal) begin
                        a_vld   <= 1'b0;
                        cap_vld <= 1'b0;
                        state   <= DONE;
                    end else if (paused_q && cap_vld) begin
                        // The byte due now was on mem_din during the pause and is lost;
                        // re-drive its address and restart the pipeline from that lane.
                        mem_a   <= base_addr + {30'b0, cap};
                        k       <= cap;
                        a_vld   <= 1'b1;
                        cap_vld <= 1'b0;
                    end else begin
                        if (cap_vld) begin
                            asm_q <= put_byte(asm_q, cap, mem_din);
                            if (cap == last) begin
                                if (owner_if) begin
                                    if_reply_en   <= 1'b1;
                                    if_reply_data <= put_byte(asm_q, cap, mem_din);
                                end else begin
                                    lsb_reply_en   <= 1'b1;
                                    lsb_reply_data <= put_byte(asm_q, cap, mem_din);
                                end
                                state <= DONE;
                            end
                        end
                        cap     <= k;
                        cap_vld <= a_vld;
                        if (a_vld) begin
                            if (k == last) begin
                                a_vld <= 1'b0;
                            end else begin
                                k     <= k + 2'd1;
                                mem_a <= base_addr + {30'b0, k + 2'd1};
                            end
                        end
                    end
                end
                WRITE: begin
                    // A committed store always runs to completion, flush or not.
                    if (!io_blk) begin
                        if (k == last) begin
                            wr_q           <= 1'b0;
                            lsb_reply_en   <= 1'b1;
                            lsb_reply_data <= '0;
                            state          <= DONE;
                        end else begin
                            k        <= k + 2'd1;
                            mem_a    <= base_addr + {30'b0, k + 2'd1};
                            mem_dout <= get_byte(wdata, k + 2'd1);
                        end
                    end
                end
                DONE: begin
                    // Clients drop their request during this cycle.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_controller.sv
// Scoreboard bench for mem_controller: stimulus pushes expected replies and
// RAM writes into queues, a negedge monitor pops and compares them.
module tb_mem_controller;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        flush_signal;
    logic        lsb_query_en;
    logic        lsb_query_type;
    logic [31:0] lsb_query_addr;
    logic [1:0]  lsb_data_width;
    logic [31:0] lsb_query_data;
    logic        lsb_reply_en;
    logic [31:0] lsb_reply_data;
    logic        if_query_en;
    logic [31:0] if_query_addr;
    logic        if_reply_en;
    logic [31:0] if_reply_data;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_lsb[$];
    logic [31:0] exp_if[$];
    logic [39:0] exp_wr[$];
    logic [31:0] mon_exp;
    logic [39:0] mon_wr;

    logic [7:0] ram [0:4095];

    mem_controller dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .flush_signal   (flush_signal),
        .lsb_query_en   (lsb_query_en),
        .lsb_query_type (lsb_query_type),
        .lsb_query_addr (lsb_query_addr),
        .lsb_data_width (lsb_data_width),
        .lsb_query_data (lsb_query_data),
        .lsb_reply_en   (lsb_reply_en),
        .lsb_reply_data (lsb_reply_data),
        .if_query_en    (if_query_en),
        .if_query_addr  (if_query_addr),
        .if_reply_en    (if_reply_en),
        .if_reply_data  (if_reply_data),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full)
    );

    always #5 clk_in = ~clk_in;

    // RAM model: registered read, one cycle latency; IO addresses are not stored.
    always @(posedge clk_in) begin
        mem_din <= ram[mem_a[11:0]];
        if (mem_wr === 1'b1 && mem_a[17:16] != 2'b11) ram[mem_a[11:0]] <= mem_dout;
    end

    // Monitor: compare every reply pulse and every RAM write against the queues.
    always @(negedge clk_in) begin
        if (lsb_reply_en === 1'b1) begin
            n_cmp++;
            if (exp_lsb.size() == 0) begin
                n_bad++;
                $display("FAIL lsb_reply unexpected: got %h, none expected", lsb_reply_data);
            end else begin
                mon_exp = exp_lsb.pop_front();
                if (lsb_reply_data !== mon_exp) begin
                    n_bad++;
                    $display("FAIL lsb_reply_data: got %h, want %h", lsb_reply_data, mon_exp);
                end
            end
        end
        if (if_reply_en === 1'b1) begin
            n_cmp++;
            if (exp_if.size() == 0) begin
                n_bad++;
                $display("FAIL if_reply unexpected: got %h, none expected", if_reply_data);
            end else begin
                mon_exp = exp_if.pop_front();
                if (if_reply_data !== mon_exp) begin
                    n_bad++;
                    $display("FAIL if_reply_data: got %h, want %h", if_reply_data, mon_exp);
                end
            end
        end
        if (mem_wr === 1'b1) begin
            n_cmp++;
            if (exp_wr.size() == 0) begin
                n_bad++;
                $display("FAIL mem_write unexpected: got %h<=%h, none expected", mem_a, mem_dout);
            end else begin
                mon_wr = exp_wr.pop_front();
                if ({mem_a, mem_dout} !== mon_wr) begin
                    n_bad++;
                    $display("FAIL mem_write: got %h<=%h, want %h<=%h",
                             mem_a, mem_dout, mon_wr[39:8], mon_wr[7:0]);
                end
            end
        end
        if (io_buffer_full === 1'b1 && mem_a[17:16] == 2'b11) begin
            n_cmp++;
            if (mem_wr !== 1'b0) begin
                n_bad++;
                $display("FAIL io_hold mem_wr: got %b, want 0", mem_wr);
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, got, want);
        end
    endtask

    // Count edges from request assertion until the reply pulse is seen.
    task automatic wait_reply(input bit is_if, input int exp_cnt, input string nm);
        int cnt;
        bit seen;
        cnt  = 0;
        seen = 0;
        while (!seen && cnt < 60) begin
            @(posedge clk_in);
            cnt++;
            @(negedge clk_in);
            if ((is_if ? if_reply_en : lsb_reply_en) === 1'b1) seen = 1;
        end
        n_cmp++;
        if (!seen || cnt != exp_cnt) begin
            n_bad++;
            $display("FAIL %s latency: got %0d cycles (seen=%0d), want %0d", nm, cnt, seen, exp_cnt);
        end
    endtask

    task automatic lsb_txn(input bit wr, input logic [31:0] a, input logic [1:0] w,
                           input logic [31:0] d, input int exp_cnt, input string nm);
        @(posedge clk_in);
        #1;
        lsb_query_en   = 1'b1;
        lsb_query_type = wr;
        lsb_query_addr = a;
        lsb_data_width = w;
        lsb_query_data = d;
        wait_reply(1'b0, exp_cnt, nm);
        @(posedge clk_in);
        #1;
        lsb_query_en = 1'b0;
    endtask

    task automatic if_txn(input logic [31:0] a, input int exp_cnt, input string nm);
        @(posedge clk_in);
        #1;
        if_query_en   = 1'b1;
        if_query_addr = a;
        wait_reply(1'b1, exp_cnt, nm);
        @(posedge clk_in);
        #1;
        if_query_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen_if;
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[12'h000] = 8'hA1; ram[12'h001] = 8'hB2; ram[12'h002] = 8'hC3; ram[12'h003] = 8'hD4;
        ram[12'h010] = 8'h7E;
        ram[12'h100] = 8'h11; ram[12'h101] = 8'h22; ram[12'h102] = 8'h33; ram[12'h103] = 8'h44;
        ram[12'hFFE] = 8'h55; ram[12'hFFF] = 8'h66;

        rst_in = 1'b1; rdy_in = 1'b1; flush_signal = 1'b0; io_buffer_full = 1'b0;
        lsb_query_en = 1'b0; lsb_query_type = 1'b0; lsb_query_addr = '0;
        lsb_data_width = '0; lsb_query_data = '0; if_query_en = 1'b0; if_query_addr = '0;
        repeat (2) @(posedge clk_in);
        #1;
        check("reset mem_a", mem_a, 32'h0);
        check("reset mem_dout", {24'h0, mem_dout}, 32'h0);
        check("reset mem_wr", {31'h0, mem_wr}, 32'h0);
        check("reset lsb_reply_en", {31'h0, lsb_reply_en}, 32'h0);
        check("reset lsb_reply_data", lsb_reply_data, 32'h0);
        check("reset if_reply_en", {31'h0, if_reply_en}, 32'h0);
        check("reset if_reply_data", if_reply_data, 32'h0);
        rst_in = 1'b0;

        // lw 0x100
        exp_lsb.push_back(32'h44332211);
        lsb_txn(1'b0, 32'h100, 2'd2, 32'h0, 6, "lw_0x100");

        // sh 0x202; request held through DONE must not be re-accepted
        exp_wr.push_back({32'h202, 8'hEF});
        exp_wr.push_back({32'h203, 8'hBE});
        exp_lsb.push_back(32'h0);
        lsb_txn(1'b1, 32'h202, 2'd1, 32'hDEADBEEF, 3, "sh_0x202");

        exp_lsb.push_back(32'h0000BEEF);
        lsb_txn(1'b0, 32'h202, 2'd1, 32'h0, 4, "lh_0x202");

        // simultaneous lb and fetch: LSB first, fetch after DONE
        exp_lsb.push_back(32'h0000007E);
        exp_if.push_back(32'hD4C3B2A1);
        fork
            lsb_txn(1'b0, 32'h10, 2'd0, 32'h0, 3, "lb_0x10_arb");
            if_txn(32'h0, 10, "if_0x0_arb");
        join

        // flush after two fetch bytes captured: no reply
        @(posedge clk_in);
        #1;
        if_query_en = 1'b1;
        if_query_addr = 32'h0;
        repeat (4) @(posedge clk_in);
        #1;
        flush_signal = 1'b1;
        if_query_en = 1'b0;
        @(posedge clk_in);
        #1;
        flush_signal = 1'b0;
        seen_if = 0;
        repeat (6) begin
            @(negedge clk_in);
            if (if_reply_en === 1'b1) seen_if++;
        end
        check("flush_if no reply", seen_if, 0);

        // flush in IDLE: request accepted one cycle later
        exp_lsb.push_back(32'h00000044);
        @(posedge clk_in);
        #1;
        lsb_query_en = 1'b1; lsb_query_type = 1'b0; lsb_query_addr = 32'h103;
        lsb_data_width = 2'd0; flush_signal = 1'b1;
        @(posedge clk_in);
        #1;
        flush_signal = 1'b0;
        wait_reply(1'b0, 3, "lb_after_idle_flush");
        @(posedge clk_in);
        #1;
        lsb_query_en = 1'b0;

        // flush during sw: all bytes still written and reply pulsed
        exp_wr.push_back({32'h300, 8'h0D});
        exp_wr.push_back({32'h301, 8'hF0});
        exp_wr.push_back({32'h302, 8'hFE});
        exp_wr.push_back({32'h303, 8'hCA});
        exp_lsb.push_back(32'h0);
        fork
            lsb_txn(1'b1, 32'h300, 2'd2, 32'hCAFEF00D, 5, "sw_flush");
            begin
                repeat (3) @(posedge clk_in);
                #1;
                flush_signal = 1'b1;
                @(posedge clk_in);
                #1;
                flush_signal = 1'b0;
            end
        join
        exp_lsb.push_back(32'hCAFEF00D);
        lsb_txn(1'b0, 32'h300, 2'd2, 32'h0, 6, "lw_0x300");

        // sb to IO with buffer full for three write cycles
        exp_wr.push_back({32'h30000, 8'h5A});
        exp_lsb.push_back(32'h0);
        io_buffer_full = 1'b1;
        fork
            lsb_txn(1'b1, 32'h30000, 2'd0, 32'h0000005A, 5, "sb_io_full");
            begin
                repeat (5) @(posedge clk_in);
                #1;
                io_buffer_full = 1'b0;
            end
        join

        // lw with two pause cycles right after acceptance
        exp_lsb.push_back(32'h44332211);
        fork
            lsb_txn(1'b0, 32'h100, 2'd2, 32'h0, 8, "lw_pause");
            begin
                repeat (2) @(posedge clk_in);
                #1;
                rdy_in = 1'b0;
                repeat (2) @(posedge clk_in);
                #1;
                rdy_in = 1'b1;
            end
        join

        // sh with a pause on its first write cycle: byte must not be written twice
        exp_wr.push_back({32'h400, 8'h5A});
        exp_wr.push_back({32'h401, 8'hA5});
        exp_lsb.push_back(32'h0);
        fork
            lsb_txn(1'b1, 32'h400, 2'd1, 32'h1234A55A, 4, "sh_pause");
            begin
                repeat (2) @(posedge clk_in);
                #1;
                rdy_in = 1'b0;
                @(posedge clk_in);
                #1;
                rdy_in = 1'b1;
            end
        join

        // reset during sw: bytes presented before the reset edge land, the rest do not
        exp_wr.push_back({32'h500, 8'h44});
        exp_wr.push_back({32'h501, 8'h33});
        exp_wr.push_back({32'h502, 8'h22});
        @(posedge clk_in);
        #1;
        lsb_query_en = 1'b1; lsb_query_type = 1'b1; lsb_query_addr = 32'h500;
        lsb_data_width = 2'd2; lsb_query_data = 32'h11223344;
        repeat (3) @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        lsb_query_en = 1'b0;
        @(posedge clk_in);
        #1;
        check("rst_mid mem_a", mem_a, 32'h0);
        check("rst_mid mem_dout", {24'h0, mem_dout}, 32'h0);
        check("rst_mid mem_wr", {31'h0, mem_wr}, 32'h0);
        check("rst_mid lsb_reply_en", {31'h0, lsb_reply_en}, 32'h0);
        check("rst_mid lsb_reply_data", lsb_reply_data, 32'h0);
        check("rst_mid if_reply_data", if_reply_data, 32'h0);
        rst_in = 1'b0;

        // width 3 acts as word; address wraps past 0xFFFFFFFF
        exp_lsb.push_back(32'hB2A16655);
        lsb_txn(1'b0, 32'hFFFFFFFE, 2'd3, 32'h0, 6, "lw_wrap");

        exp_lsb.push_back(32'h00223344);
        lsb_txn(1'b0, 32'h500, 2'd2, 32'h0, 6, "lw_0x500");

        repeat (3) @(posedge clk_in);
        #1;
        check("leftover expectations", exp_lsb.size() + exp_if.size() + exp_wr.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
